// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM states and default sizes.
package mul_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mul_state_t;
endpackage

// File: rtl/mul_iter_dp.sv
// Shift-add datapath: magnitude operands, 2*WIDTH accumulator and result sign.
module mul_iter_dp #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc,
   output logic [2*WIDTH-1:0] acc_neg,
   output logic               neg
);
   logic [2*WIDTH-1:0] ma;
   logic [WIDTH-1:0]   mb;
   logic [WIDTH-1:0]   a_mag, b_mag;

   // The most negative value negates to itself, which is correct when read unsigned.
   assign a_mag   = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign b_mag   = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
   assign acc_neg = ~acc + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         ma  <= '0;
         mb  <= '0;
         acc <= '0;
         neg <= 1'b0;
      end else if (load) begin
         ma  <= {{WIDTH{1'b0}}, a_mag};
         mb  <= b_mag;
         acc <= '0;
         neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (step) begin
         if (mb[0]) acc <= acc + ma;
         ma <= ma << 1;
         mb <= mb >> 1;
      end
   end
endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MULT/MULTU sequencer: runs the shift-add datapath, applies sign, commits HI/LO.
module mul_seq_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   mul_state_t         state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               load, step, commit;
   logic [2*WIDTH-1:0] acc, acc_neg, product;
   logic               neg;

   mul_iter_dp #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .is_signed(is_signed),
      .a        (a),
      .b        (b),
      .acc      (acc),
      .acc_neg  (acc_neg),
      .neg      (neg)
   );

   assign product = neg ? acc_neg : acc;
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: if (start && !flush) begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            if (flush) state_nxt = IDLE;
            else begin
               step = 1'b1;
               if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            end
         end
         FIX: begin
            if (flush) state_nxt = IDLE;
            else begin
               commit    = 1'b1;
               state_nxt = DONE;
            end
         end
         // Commit already happened, so flush is ignored here.
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         done  <= commit;
         if (load)      cnt <= '0;
         else if (step) cnt <= cnt + 1'b1;
         if (commit) {hi, lo} <= product;
      end
   end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: latency, signed/unsigned products, flush, reset abort.
module tb_mul_seq_ctrl;
   logic        clk = 1'b0;
   logic        reset, start, is_signed, flush;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;
   int          cmp_n = 0;
   int          err_n = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // Launch one op; inj>0 pulses a second start (1*1) before edge N+inj.
   task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int inj, input string name);
      int done_k, busy_n, pulses;
      start = 1'b1; is_signed = s; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      done_k = -1; pulses = 0;
      busy_n = busy ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == inj) begin start = 1'b1; a = 32'd1; b = 32'd1; end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin pulses++; if (done_k < 0) done_k = k; end
         if (busy) busy_n++;
      end
      cmp_n++; if (done_k !== 33) begin err_n++; $display("FAIL %s done_edge got %0d want 33", name, done_k); end
      cmp_n++; if (pulses !== 1) begin err_n++; $display("FAIL %s done_pulses got %0d want 1", name, pulses); end
      cmp_n++; if (busy_n !== 34) begin err_n++; $display("FAIL %s busy_cycles got %0d want 34", name, busy_n); end
      cmp_n++; if (hi !== eh) begin err_n++; $display("FAIL %s hi got %h want %h", name, hi, eh); end
      cmp_n++; if (lo !== el) begin err_n++; $display("FAIL %s lo got %h want %h", name, lo, el); end
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL reset_busy got %b want 0", busy); end
      cmp_n++; if (done !== 1'b0) begin err_n++; $display("FAIL reset_done got %b want 0", done); end
      cmp_n++; if (hi !== 32'h0) begin err_n++; $display("FAIL reset_hi got %h want 0", hi); end
      cmp_n++; if (lo !== 32'h0) begin err_n++; $display("FAIL reset_lo got %h want 0", lo); end
      reset = 1'b0;
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad++;
      end
      cmp_n++; if (bad !== 0) begin err_n++; $display("FAIL idle_hold bad_cycles got %0d want 0", bad); end
   endtask

   task automatic test_multu();
      run_op(1'b0, 32'd3, 32'd5, 32'h0, 32'h0000000F, 0, "multu_small");
      run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, "multu_max");
   endtask

   task automatic test_mult();
      run_op(1'b1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, "mult_neg2x3");
      run_op(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, "mult_minxmin");
      run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, "mult_m1xm1");
   endtask

   task automatic test_flush();
      int pulses;
      run_op(1'b0, 32'd3, 32'd5, 32'h0, 32'd15, 0, "pre_flush");
      start = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL flush_busy got %b want 0", busy); end
      pulses = 0;
      repeat (30) begin @(posedge clk); #1; if (done) pulses++; end
      cmp_n++; if (pulses !== 0) begin err_n++; $display("FAIL flush_done_pulses got %0d want 0", pulses); end
      cmp_n++; if ({hi, lo} !== {32'h0, 32'd15}) begin err_n++; $display("FAIL flush_hilo got %h_%h want 0_f", hi, lo); end
      // Flush coinciding with start in IDLE must not launch anything.
      start = 1'b1; flush = 1'b1; a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL flush_start_busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 32'd7, 32'd9, 32'h0, 32'd63, 5, "start_while_busy");
   endtask

   task automatic test_reset_midop();
      int pulses;
      start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL midrst_busy got %b want 0", busy); end
      cmp_n++; if ({hi, lo} !== 64'h0) begin err_n++; $display("FAIL midrst_hilo got %h_%h want 0_0", hi, lo); end
      pulses = 0;
      repeat (20) begin @(posedge clk); #1; if (done || busy) pulses++; end
      cmp_n++; if (pulses !== 0) begin err_n++; $display("FAIL midrst_activity got %0d want 0", pulses); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_flush();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end
endmodule
